screen_fill: RTL
================

Name: screen_fill

Overview:
- Second initiator on the screen-writer pixel protocol, alongside the triangle rasteriser; screen_writer is the responder.
- Accepts a rectangle fill request: inclusive corners, colour, mode. Clips the rectangle to the screen and issues one bounding-box job to the screen writer.
- Answers the writer's per-pixel iteration with a new colour, then reports completion.
- Used for frame clears, HUD boxes and borders between mesh draws.

Parameters:
- WIDTH, 32, width of all coordinate and range buses; coordinates are two's-complement signed.
- COLOUR_WIDTH, 3, pixel colour width.
- SCREEN_W, 160, screen width in pixels; valid x is 0..SCREEN_W-1.
- SCREEN_H, 120, screen height in pixels; valid y is 0..SCREEN_H-1.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- fill_en  in  1  request strobe; sampled only in IDLE.
- x0, y0  in  WIDTH  first corner (signed, inclusive).
- x1, y1  in  WIDTH  opposite corner (signed, inclusive); corners may arrive in any order.
- colour  in  COLOUR_WIDTH  fill colour.
- mode  in  2  0 = solid, 1 = border, 2 = checker, 3 = invert.
- busy  out  1  high from acceptance of a request through the fill_done cycle.
- fill_done  out  1  one-cycle completion pulse.
- screen_start  out  1  one-cycle job pulse to the writer.
- screen_x_min, screen_y_min  out  WIDTH  clipped box origin.
- screen_x_range, screen_y_range  out  WIDTH  box size in pixels (count, >= 1).
- new_screen_colour  out  COLOUR_WIDTH  colour for the pixel currently presented.
- screen_x, screen_y  in  WIDTH  pixel currently presented by the writer.
- old_screen_colour  in  COLOUR_WIDTH  stored colour of that pixel.
- screen_done  in  1  writer's job-complete pulse.

Behaviour:
- Reset:
  - state = IDLE.
  - busy, fill_done, screen_start = 0.
  - All screen_* outputs = 0.
  - Latched request registers = 0.
  - Reset in any state aborts immediately: no fill_done is produced, and a later screen_done is ignored.
- States: IDLE, CLIP, START, WAIT, DONE.
- IDLE:
  - On fill_en at edge t, latch the request (sorted corners, colour, mode) and go to CLIP.
  - busy = 1 from t+1.
- CLIP, one cycle:
  - Sort corners: lx = min(x0,x1), hx = max(x0,x1); ly and hy likewise.
  - Clamp: cx0 = max(lx,0), cx1 = min(hx,SCREEN_W-1); cy0 and cy1 likewise against SCREEN_H-1.
  - If cx0 > cx1 or cy0 > cy1, the box is empty and goes to DONE.
  - Otherwise register screen_x_min = cx0, screen_x_range = cx1-cx0+1 (y the same) and go to START.
  - All comparisons are signed WIDTH.
- START: screen_start = 1 for exactly this cycle, then go to WAIT.
- WAIT:
  - Box outputs are held stable.
  - new_screen_colour is combinational from screen_x, screen_y and old_screen_colour:
    - solid: colour.
    - border: colour if screen_x is lx or hx, or screen_y is ly or hy (unclipped edges, so a box clipped by the screen edge shows no border there); otherwise old_screen_colour.
    - checker: colour if screen_x[0]^screen_y[0] = 0, else old_screen_colour.
    - invert: ~old_screen_colour.
  - Go to DONE on screen_done.
- Outside WAIT, new_screen_colour = 0.
- DONE:
  - fill_done = 1 and busy = 1 for this one cycle; back to IDLE.
  - A new fill_en is accepted from the following cycle.
- Latency:
  - Non-empty box: screen_start at t+3 (t = acceptance edge); fill_done one cycle after screen_done.
  - Empty box: fill_done at t+2, no screen_start.
- Ignored inputs:
  - fill_en while busy is dropped, not queued.
  - screen_done outside WAIT is ignored.
  - screen_done arriving in the same cycle as screen_start is ignored; the writer's done is only counted once in WAIT.

Decomposition:
- Shared graphics package holds:
  - mode encodings FILL_SOLID, FILL_BORDER, FILL_CHECKER, FILL_INVERT;
  - SCREEN_W and SCREEN_H defaults;
  - the state enumeration.
- One sub-module, fill_clip: combinational sort and clamp. Outputs the clipped min and range per axis, the empty flag and the sorted unclipped bounds. Reused later by the triangle path's bounding-box logic.

Test Plan:
1. Solid fill, (10,20)-(12,21), colour 5 -> screen_start at t+3 with x_min = 10, y_min = 20, x_range = 3, y_range = 2; every presented pixel gets 5; fill_done 1 cycle after screen_done; busy low the cycle after that.
2. Swapped and off-screen corners, (200,-5)-(150,10) -> x_min = 150, x_range = 10, y_min = 0, y_range = 11.
3. Fully off-screen, (-10,-10)-(-1,-1) -> no screen_start; fill_done at t+2.
4. Border mode, box (0,0)-(3,3), colour 7, old colour 2 -> (0,1) gives 7, (1,1) gives 2, (3,3) gives 7. Checker mode: (1,0) gives old, (1,1) gives 7. Invert mode: old 3'b010 gives 3'b101.
5. fill_en pulsed again during WAIT -> ignored; exactly one fill_done. screen_done driven in IDLE -> no response.
6. Reset asserted in WAIT, then screen_done -> all outputs 0; no fill_done; the next request runs normally with nominal latency.

Source files
------------

// File: rtl/screen_fill_pkg.sv
// Shared graphics definitions for the screen fill initiator.
// Fill modes, default screen geometry and the fill FSM states.
package screen_fill_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  localparam logic [1:0] FILL_SOLID   = 2'd0;
  localparam logic [1:0] FILL_BORDER  = 2'd1;
  localparam logic [1:0] FILL_CHECKER = 2'd2;
  localparam logic [1:0] FILL_INVERT  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLIP,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/fill_clip.sv
// Sorts two signed corners and clamps the box to the screen.
// Gives clipped origin/size per axis, empty flag and raw bounds.
module fill_clip #(
  parameter int WIDTH    = 32,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic signed [WIDTH-1:0] x0,
  input  logic signed [WIDTH-1:0] y0,
  input  logic signed [WIDTH-1:0] x1,
  input  logic signed [WIDTH-1:0] y1,
  output logic signed [WIDTH-1:0] lx,
  output logic signed [WIDTH-1:0] hx,
  output logic signed [WIDTH-1:0] ly,
  output logic signed [WIDTH-1:0] hy,
  output logic        [WIDTH-1:0] x_min,
  output logic        [WIDTH-1:0] y_min,
  output logic        [WIDTH-1:0] x_range,
  output logic        [WIDTH-1:0] y_range,
  output logic                    empty
);

  localparam logic signed [WIDTH-1:0] XMAX = WIDTH'(SCREEN_W - 1);
  localparam logic signed [WIDTH-1:0] YMAX = WIDTH'(SCREEN_H - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic signed [WIDTH-1:0] cx0, cx1, cy0, cy1;

  always_comb begin
    lx = (x0 < x1) ? x0 : x1;
    hx = (x0 < x1) ? x1 : x0;
    ly = (y0 < y1) ? y0 : y1;
    hy = (y0 < y1) ? y1 : y0;
    // negative lower bounds clamp to the screen origin
    cx0 = lx[WIDTH-1] ? '0 : lx;
    cy0 = ly[WIDTH-1] ? '0 : ly;
    cx1 = (hx > XMAX) ? XMAX : hx;
    cy1 = (hy > YMAX) ? YMAX : hy;
    empty = (cx0 > cx1) || (cy0 > cy1);
    x_min = cx0;
    y_min = cy0;
    x_range = WIDTH'(cx1 - cx0) + ONE;
    y_range = WIDTH'(cy1 - cy0) + ONE;
  end

endmodule

// File: rtl/screen_fill.sv
// Rectangle fill initiator on the screen-writer pixel protocol.
// Clips a request, issues one job, recolours presented pixels.
module screen_fill
  import screen_fill_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int COLOUR_WIDTH = 3,
  parameter int SCREEN_W     = SCREEN_W_DEF,
  parameter int SCREEN_H     = SCREEN_H_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    fill_en,
  input  logic [WIDTH-1:0]        x0,
  input  logic [WIDTH-1:0]        y0,
  input  logic [WIDTH-1:0]        x1,
  input  logic [WIDTH-1:0]        y1,
  input  logic [COLOUR_WIDTH-1:0] colour,
  input  logic [1:0]              mode,
  output logic                    busy,
  output logic                    fill_done,
  output logic                    screen_start,
  output logic [WIDTH-1:0]        screen_x_min,
  output logic [WIDTH-1:0]        screen_y_min,
  output logic [WIDTH-1:0]        screen_x_range,
  output logic [WIDTH-1:0]        screen_y_range,
  output logic [COLOUR_WIDTH-1:0] new_screen_colour,
  input  logic [WIDTH-1:0]        screen_x,
  input  logic [WIDTH-1:0]        screen_y,
  input  logic [COLOUR_WIDTH-1:0] old_screen_colour,
  input  logic                    screen_done
);

  state_t state;

  logic signed [WIDTH-1:0] rx0, ry0, rx1, ry1;
  logic [COLOUR_WIDTH-1:0] rcolour;
  logic [1:0]              rmode;

  logic signed [WIDTH-1:0] lx, hx, ly, hy;
  logic [WIDTH-1:0] x_min, y_min, x_range, y_range;
  logic empty;
  logic on_edge;

  fill_clip #(
    .WIDTH   (WIDTH),
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H)
  ) clip (
    .x0     (rx0),
    .y0     (ry0),
    .x1     (rx1),
    .y1     (ry1),
    .lx     (lx),
    .hx     (hx),
    .ly     (ly),
    .hy     (hy),
    .x_min  (x_min),
    .y_min  (y_min),
    .x_range(x_range),
    .y_range(y_range),
    .empty  (empty)
  );

  // border uses unclipped edges so clipped sides stay open
  assign on_edge = (screen_x == lx) || (screen_x == hx) ||
                   (screen_y == ly) || (screen_y == hy);

  always_comb begin
    new_screen_colour = '0;
    if (state == S_WAIT) begin
      unique case (rmode)
        FILL_SOLID:   new_screen_colour = rcolour;
        FILL_BORDER:  new_screen_colour = on_edge ? rcolour
                                                  : old_screen_colour;
        FILL_CHECKER: new_screen_colour = (screen_x[0] ^ screen_y[0])
                                          ? old_screen_colour : rcolour;
        default:      new_screen_colour = ~old_screen_colour;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      fill_done      <= 1'b0;
      screen_start   <= 1'b0;
      screen_x_min   <= '0;
      screen_y_min   <= '0;
      screen_x_range <= '0;
      screen_y_range <= '0;
      rx0            <= '0;
      ry0            <= '0;
      rx1            <= '0;
      ry1            <= '0;
      rcolour        <= '0;
      rmode          <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (fill_en) begin
            rx0     <= x0;
            ry0     <= y0;
            rx1     <= x1;
            ry1     <= y1;
            rcolour <= colour;
            rmode   <= mode;
            busy    <= 1'b1;
            state   <= S_CLIP;
          end
        end
        S_CLIP: begin
          if (empty) begin
            fill_done <= 1'b1;
            state     <= S_DONE;
          end else begin
            screen_x_min   <= x_min;
            screen_y_min   <= y_min;
            screen_x_range <= x_range;
            screen_y_range <= y_range;
            state          <= S_START;
          end
        end
        S_START: begin
          screen_start <= 1'b1;
          state        <= S_WAIT;
        end
        S_WAIT: begin
          screen_start <= 1'b0;
          // a done coinciding with the start pulse is stale
          if (screen_done && !screen_start) begin
            fill_done <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          fill_done <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
